ps2_mouse_rx: RTL and testbench
===============================

# ps2_mouse_rx

Receives the raw PS/2 mouse serial stream (device-driven clock and data) and assembles standard 3-byte movement packets into the 25-bit `ps2_mouse` word with a toggle strobe. This is the word that the core-side analog-axis emulation consumes. The block sits between the PS/2 pins or bridge and any consumer of `ps2_mouse`. It supplies the producer side of that bus inside the core, with filtering, framing checks, packet resynchronisation and timeout recovery.

## Interface
Parameters:
- `FILTER`, default 8: consecutive `clk_sys` cycles a synchronised PS/2 clock level must hold before it is accepted (range 1–255).
- `TIMEOUT`, default 100000: `clk_sys` cycles without an accepted falling edge before an in-progress frame is aborted.

Ports:
- `clk_sys`, in, 1: system clock; the only clock.
- `reset`, in, 1: synchronous, active-high.
- `ps2_clk`, in, 1: raw PS/2 clock, asynchronous, idle high.
- `ps2_dat`, in, 1: raw PS/2 data, asynchronous, idle high.
- `ps2_mouse`, out, 25: packet word.
  - [7:0] status byte: b0 left, b1 right, b2 middle, b3 always 1, b4 X sign, b5 Y sign, b6 X overflow, b7 Y overflow.
  - [15:8] X.
  - [23:16] Y.
  - [24] toggles once per accepted packet.
- `err`, out, 1: one-cycle pulse on any discarded byte or frame.
- `err_code`, out, 2: cause of the last `err`, held until the next one. 0 = sync bit missing, 1 = bad start/stop, 2 = parity, 3 = timeout.

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_dat` each pass through two synchroniser flops (`s1`, `s2`), both reset to 1.
- **Clock filter:** `clk_f` (reset 1) takes the value of the synchronised clock on the edge at which that value has differed from `clk_f` for FILTER consecutive cycles. Any agreeing cycle clears the filter count.
- **Edge detect:** `fall` = `clk_f_prev` & ~`clk_f`. `clk_f_prev` is a register, reset 1.
- **Frame receiver:** `bitcnt` runs 0..10.
  - On each `fall`, sample the synchronised data into shift position `bitcnt`, then increment `bitcnt`.
  - Frame order: start(0), D0..D7 LSB first, odd parity, stop(1).
- **End of frame:** on the `fall` where `bitcnt` = 10, evaluate the frame and return `bitcnt` to 0.
  - If start ≠ 0 or stop ≠ 1: error code 1.
  - Else if the XOR of D0..D7 and parity is 0: error code 2.
  - Else the byte is valid.
- **Packet assembler:** `idx` runs 0..2.
  - At idx 0: a valid byte with b3 = 1 is stored and idx becomes 1. A valid byte with b3 = 0 is dropped, idx stays 0, error code 0.
  - At idx 1: store X, idx becomes 2.
  - At idx 2: write `ps2_mouse[23:0]` = {Y, X, status} in a single update, invert `ps2_mouse[24]`, idx becomes 0.
- **Framing or parity error:** drop the byte, set idx to 0 (full resync), and leave `ps2_mouse` unchanged.
- **Timeout:** `tcnt` counts cycles while `bitcnt` ≠ 0, and clears on each `fall` and whenever `bitcnt` = 0. When `tcnt` reaches TIMEOUT−1:
  - set `bitcnt` and idx to 0;
  - pulse `err` with code 3.
- **Timeout boundary:** a timeout and a `fall` in the same cycle resolve in favour of the `fall`, so no timeout is raised.
- **No partial updates:** `ps2_mouse` never shows a partially assembled packet. Bytes 0 and 1 are held in internal registers until byte 2 is accepted.
- **Reset values:** on `reset`, all state returns to its reset value, including mid-frame and mid-packet.
  - `ps2_mouse` = 0, `err` = 0, `err_code` = 0.
  - `bitcnt`, idx and `tcnt` = 0.
  - All synchroniser and filter flops = 1; filter count = 0.

## Timing
- **Edge to `fall`:** a raw falling edge first sampled low at `clk_sys` edge k gives `clk_f` = 0 after edge k+1+FILTER. `fall` is high during the following cycle.
- **Stop bit to outputs:** for the stop bit of a frame, `ps2_mouse`, `err` and `err_code` update on edge k+2+FILTER. That is FILTER+2 edges after k, with no variation.
- **Data sampling point:** data is sampled from the synchronised data flop in the `fall` cycle. The data line therefore has about FILTER+2 cycles of setup relative to the raw clock edge; PS/2 provides at least 5 µs.
- **Pulse width:** `err` is high for exactly 1 cycle per event. Two events cannot occur closer than one PS/2 bit period.
- **Throughput:** one packet per 33 PS/2 clocks. The `ps2_mouse[24]` toggle rate is bounded by the device.
- **Glitch rejection:** a clock glitch shorter than FILTER cycles produces no `fall`.

## Test plan
- **Reset state:** hold `reset` for 3 cycles with `ps2_clk`/`ps2_dat` = 1 → all outputs 0 and no `err` for 10k cycles.
- **Valid packet:** send bytes 0x09, 0x05, 0xFB at a 12 kHz PS/2 clock, FILTER = 8 → `ps2_mouse` = 0x1FB0509 exactly FILTER+2 edges after the stop-bit clock is first sampled low. A second identical packet gives 0x0FB0509.
- **Parity error:** corrupt the parity of the second byte, then send a valid packet 0x08, 0x10, 0x20 → `err` pulse with code 2, `ps2_mouse[23:0]` unchanged by the bad packet, then 0x201008 with the toggle flipped once.
- **Sync-bit resync:** send 0x00 (b3 = 0), then 0x0A, 0x01, 0x02 → `err` code 0 once, then the packet 0x02010A is accepted.
- **Timeout:** with TIMEOUT = 1000, stop after 5 bits and idle → `err` code 3 exactly 1000 cycles after the last `fall`. A following valid packet is accepted normally.
- **Glitch and reset:** inject 5-cycle low glitches on `ps2_clk` with FILTER = 8 → no bit is counted. Assert `reset` mid-byte-2 → the toggle stays 0 and the next full packet decodes correctly.

Source files
------------

// File: rtl/ps2_mouse_if.sv
// ps2_mouse_if
//   Carries the assembled PS/2 mouse packet word and its error reporting
//   from the receiver (master) to any consumer (slave).
//
//   ps2_mouse[7:0]   status byte (buttons, signs, overflows, b3 always 1)
//   ps2_mouse[15:8]  X movement
//   ps2_mouse[23:16] Y movement
//   ps2_mouse[24]    toggles once per accepted packet
//   err              one-cycle pulse per discarded byte or frame
//   err_code         cause of the last err: 0 sync bit, 1 start/stop,
//                    2 parity, 3 timeout
interface ps2_mouse_if;
    logic [24:0] ps2_mouse;
    logic        err;
    logic [1:0]  err_code;

    modport master (output ps2_mouse, output err, output err_code);
    modport slave  (input  ps2_mouse, input  err, input  err_code);
endinterface

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx
//   Receives the device-driven PS/2 mouse stream, filters the PS/2 clock,
//   deframes 11-bit frames and assembles 3-byte movement packets into the
//   25-bit ps2_mouse word. Partial packets never reach the output; framing,
//   parity, sync-bit and timeout problems are reported on err/err_code.
//
//   clk_sys   in   system clock, only clock
//   reset     in   synchronous, active-high
//   ps2_clk   in   raw PS/2 clock (asynchronous, idle high)
//   ps2_dat   in   raw PS/2 data  (asynchronous, idle high)
//   mo        if   ps2_mouse_if.master: ps2_mouse, err, err_code
//
//   Packet byte index (idx):
//   state      | meaning
//   IDX_STATUS | waiting for status byte (b3 must be 1)
//   IDX_X      | status held, waiting for X byte
//   IDX_Y      | status and X held, Y byte completes the packet
module ps2_mouse_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_dat,
    ps2_mouse_if.master   mo
);
    localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TC_LAST   = TW'(TIMEOUT - 1);
    localparam logic [7:0]      FILT_LAST = 8'(FILTER - 1);

    typedef enum logic [1:0] {IDX_STATUS, IDX_X, IDX_Y} idx_e;

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          clk_f_q, clk_f_d, clk_f_prev_q, clk_f_prev_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    idx_e          idx_q, idx_d;
    logic [7:0]    stat_q, stat_d, x_q, x_d;
    logic [24:0]   mouse_q, mouse_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          fall;
    logic [7:0]    rx_byte;

    always_comb begin
        clk_s1_d     = ps2_clk;
        clk_s2_d     = clk_s1_q;
        dat_s1_d     = ps2_dat;
        dat_s2_d     = dat_s1_q;
        clk_f_d      = clk_f_q;
        clk_f_prev_d = clk_f_q;
        fcnt_d       = 8'd0;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        tcnt_d       = tcnt_q;
        idx_d        = idx_q;
        stat_d       = stat_q;
        x_d          = x_q;
        mouse_d      = mouse_q;
        err_d        = 1'b0;
        code_d       = code_q;
        rx_byte      = shift_q[8:1];

        // Accept a new clock level only after FILTER consecutive disagreeing cycles.
        if (clk_s2_q != clk_f_q) begin
            if (fcnt_q == FILT_LAST) begin
                clk_f_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end

        fall = clk_f_prev_q & ~clk_f_q;

        if (fall) begin
            tcnt_d = '0;
            if (bitcnt_q == 4'd10) begin
                // shift_q: [0] start, [8:1] data, [9] parity; stop is live data
                bitcnt_d = 4'd0;
                if (shift_q[0] || !dat_s2_q) begin
                    err_d  = 1'b1;
                    code_d = 2'd1;
                    idx_d  = IDX_STATUS;
                end else if (!(^shift_q[9:1])) begin
                    err_d  = 1'b1;
                    code_d = 2'd2;
                    idx_d  = IDX_STATUS;
                end else begin
                    case (idx_q)
                        IDX_STATUS: begin
                            if (rx_byte[3]) begin
                                stat_d = rx_byte;
                                idx_d  = IDX_X;
                            end else begin
                                err_d  = 1'b1;
                                code_d = 2'd0;
                            end
                        end
                        IDX_X: begin
                            x_d   = rx_byte;
                            idx_d = IDX_Y;
                        end
                        IDX_Y: begin
                            mouse_d = {~mouse_q[24], rx_byte, x_q, stat_q};
                            idx_d   = IDX_STATUS;
                        end
                        default: idx_d = IDX_STATUS;
                    endcase
                end
            end else begin
                // Right shift: after ten samples, bit 0 of the frame sits in shift_q[0].
                shift_d  = {dat_s2_q, shift_q[9:1]};
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (bitcnt_q == 4'd0) begin
            tcnt_d = '0;
        end else if (tcnt_q == TC_LAST) begin
            tcnt_d   = '0;
            bitcnt_d = 4'd0;
            idx_d    = IDX_STATUS;
            err_d    = 1'b1;
            code_d   = 2'd3;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            clk_f_q      <= 1'b1;
            clk_f_prev_q <= 1'b1;
            fcnt_q       <= 8'd0;
            bitcnt_q     <= 4'd0;
            shift_q      <= 10'd0;
            tcnt_q       <= '0;
            idx_q        <= IDX_STATUS;
            stat_q       <= 8'd0;
            x_q          <= 8'd0;
            mouse_q      <= 25'd0;
            err_q        <= 1'b0;
            code_q       <= 2'd0;
        end else begin
            clk_s1_q     <= clk_s1_d;
            clk_s2_q     <= clk_s2_d;
            dat_s1_q     <= dat_s1_d;
            dat_s2_q     <= dat_s2_d;
            clk_f_q      <= clk_f_d;
            clk_f_prev_q <= clk_f_prev_d;
            fcnt_q       <= fcnt_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            tcnt_q       <= tcnt_d;
            idx_q        <= idx_d;
            stat_q       <= stat_d;
            x_q          <= x_d;
            mouse_q      <= mouse_d;
            err_q        <= err_d;
            code_q       <= code_d;
        end
    end

    assign mo.ps2_mouse = mouse_q;
    assign mo.err       = err_q;
    assign mo.err_code  = code_q;
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb_ps2_mouse_rx
//   Drives PS/2 frames into ps2_mouse_rx and checks every cycle against a
//   byte-level packet model; literal checks pin the model's packet values.
module tb_ps2_mouse_rx;
    localparam int FILTER  = 8;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 42;
    localparam int GAP     = 100;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_mouse_if mif ();

    ps2_mouse_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .mo      (mif)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          due;
        bit          err;
        logic [1:0]  code;
        logic [24:0] mouse;
    } ev_t;

    ev_t         evq[$];
    ev_t         ev_cur;
    int          cyc = 0;
    bit          rst_at_edge = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    // Model of what the consumer should see, updated a byte at a time.
    logic [24:0] m_mouse = '0;
    int          m_idx = 0;
    logic [7:0]  m_st = '0;
    logic [7:0]  m_x = '0;

    logic [24:0] exp_mouse = '0;
    logic [1:0]  exp_code = '0;
    bit          exp_err = 1'b0;

    always @(posedge clk_sys) begin
        cyc++;
        rst_at_edge = reset;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk_sys) begin
        if (cyc > 0) begin
            if (rst_at_edge) begin
                exp_mouse = '0;
                exp_code  = '0;
                evq.delete();
            end
            exp_err = 1'b0;
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                ev_cur    = evq.pop_front();
                exp_mouse = ev_cur.mouse;
                if (ev_cur.err) begin
                    exp_err  = 1'b1;
                    exp_code = ev_cur.code;
                end
            end
            check("ps2_mouse", {7'd0, mif.ps2_mouse}, {7'd0, exp_mouse});
            check("err",       {31'd0, mif.err},      {31'd0, exp_err});
            check("err_code",  {30'd0, mif.err_code}, {30'd0, exp_code});
        end
    end

    // Outcome of one complete frame whose stop-bit clock was first sampled low at edge k.
    task automatic model_byte(input logic [7:0] d, input bit frame_ok, input bit par_ok, input int k);
        ev_t e;
        e.due   = k + FILTER + 2;
        e.err   = 1'b1;
        e.code  = 2'd0;
        e.mouse = m_mouse;
        if (!frame_ok) begin
            e.code = 2'd1;
            m_idx  = 0;
        end else if (!par_ok) begin
            e.code = 2'd2;
            m_idx  = 0;
        end else if (m_idx == 0) begin
            if (d[3]) begin
                m_st  = d;
                m_idx = 1;
                e.err = 1'b0;
            end
        end else if (m_idx == 1) begin
            m_x   = d;
            m_idx = 2;
            e.err = 1'b0;
        end else begin
            m_mouse = {~m_mouse[24], d, m_x, m_st};
            e.mouse = m_mouse;
            m_idx   = 0;
            e.err   = 1'b0;
        end
        evq.push_back(e);
    endtask

    // Sends the first nbits of a frame; a full frame (11 bits) is handed to the model.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_start,
                              input bit bad_stop, input int nbits, output int k_last);
        logic [10:0] fr;
        fr = {~bad_stop, (~^d) ^ bad_par, d, bad_start};
        k_last = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_sys);
            ps2_dat = fr[i];
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b0;
            k_last  = cyc + 1;
            if (i == 10)
                model_byte(d, !(bad_start || bad_stop), !bad_par, k_last);
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (GAP) @(negedge clk_sys);
    endtask

    task automatic send_good(input logic [7:0] d);
        int k;
        send_frame(d, 1'b0, 1'b0, 1'b0, 11, k);
    endtask

    task automatic send_packet(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
        send_good(s);
        send_good(x);
        send_good(y);
    endtask

    task automatic glitch(input int len);
        @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (len) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk_sys);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (10000) @(negedge clk_sys);
        check("reset_mouse", {7'd0, mif.ps2_mouse}, 32'h0);

        send_packet(8'h09, 8'h05, 8'hFB);
        check("pkt1", {7'd0, mif.ps2_mouse}, 32'h1FB0509);
        send_packet(8'h09, 8'h05, 8'hFB);
        check("pkt2", {7'd0, mif.ps2_mouse}, 32'h0FB0509);

        send_good(8'h09);
        send_frame(8'h05, 1'b1, 1'b0, 1'b0, 11, k);
        check("parity_code", {30'd0, mif.err_code}, 32'd2);
        check("parity_hold", {7'd0, mif.ps2_mouse}, 32'h0FB0509);
        send_packet(8'h08, 8'h10, 8'h20);
        check("pkt3", {7'd0, mif.ps2_mouse}, 32'h1201008);

        send_good(8'h00);
        check("sync_code", {30'd0, mif.err_code}, 32'd0);
        send_packet(8'h0A, 8'h01, 8'h02);
        check("pkt4", {7'd0, mif.ps2_mouse}, 32'h002010A);

        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 11, k);
        check("stop_code", {30'd0, mif.err_code}, 32'd1);

        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 5, k);
        begin
            ev_t e;
            e.due   = k + FILTER + 2 + TIMEOUT;
            e.err   = 1'b1;
            e.code  = 2'd3;
            e.mouse = m_mouse;
            evq.push_back(e);
            m_idx = 0;
        end
        repeat (TIMEOUT + 50) @(negedge clk_sys);
        check("timeout_code", {30'd0, mif.err_code}, 32'd3);
        send_packet(8'h1C, 8'h7F, 8'h80);
        check("pkt5", {7'd0, mif.ps2_mouse}, 32'h1807F1C);

        glitch(5);
        glitch(5);
        glitch(FILTER - 1);
        send_packet(8'h39, 8'h00, 8'hFF);
        check("pkt6", {7'd0, mif.ps2_mouse}, 32'h0FF0039);

        send_good(8'h0B);
        send_good(8'h33);
        send_frame(8'h44, 1'b0, 1'b0, 1'b0, 4, k);
        @(negedge clk_sys);
        reset = 1'b1;
        m_mouse = '0;
        m_idx   = 0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (20) @(negedge clk_sys);
        check("reset_toggle", {7'd0, mif.ps2_mouse}, 32'h0);
        check("reset_code", {30'd0, mif.err_code}, 32'd0);
        send_packet(8'h2C, 8'h12, 8'h34);
        check("pkt7", {7'd0, mif.ps2_mouse}, 32'h134122C);

        repeat (50) @(negedge clk_sys);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
